uart_tx_fifo: RTL

Parametrised UART transmitter with a TX FIFO and a runtime frame format: 5–8 data bits, none/even/odd parity, 1 or 2 stop bits, and a programmable bit period. It sits behind the peripheral bus UART register block. Software pushes bytes into the FIFO without polling per byte. The block serialises frames back-to-back on `txd_o`.

---
 rtl/uart_tx_fifo.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - UART transmitter with TX FIFO and runtime frame format
// Frames are serialised back-to-back from the FIFO; config is snapshotted at each pop.
module uart_tx_fifo #(
  parameter int BAUD_RATE  = 115200,
  parameter int CLK_FREQ   = 50000000,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_we_i,
  input  logic [15:0]                   bit_period_i,
  input  logic [1:0]                    data_bits_i,
  input  logic [1:0]                    parity_i,
  input  logic                          stop2_i,
  input  logic                          wr_en_i,
  input  logic [7:0]                    wr_data_i,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          overflow_o,
  output logic                          txd_o,
  output logic                          busy_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [15:0] DEF_PERIOD = 16'(CLK_FREQ / BAUD_RATE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // configuration registers
  logic [15:0] cfg_period;
  logic [1:0]  cfg_bits;
  logic [1:0]  cfg_parity;
  logic        cfg_stop2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_period <= DEF_PERIOD;
      cfg_bits   <= 2'b11;
      cfg_parity <= 2'b00;
      cfg_stop2  <= 1'b0;
    end else if (cfg_we_i) begin
      cfg_period <= bit_period_i;
      cfg_bits   <= data_bits_i;
      cfg_parity <= parity_i;
      cfg_stop2  <= stop2_i;
    end
  end

  // FIFO
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [7:0]    head;
  logic          overflow;

  assign full  = (count == LW'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign push  = wr_en_i && !full;
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= wr_en_i && full;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  // transmit FSM and datapath
  state_t      state, state_next;
  logic [15:0] cnt;
  logic [15:0] snap_period;
  logic [7:0]  shreg;
  logic [2:0]  bit_idx;
  logic [2:0]  last_idx;
  logic        par_en;
  logic        par_bit;
  logic        snap_stop2;
  logic        stop_second;
  logic        txd, txd_next;
  logic        bit_end;
  logic        shift;
  logic        stop_advance;
  logic [7:0]  data_mask;

  assign bit_end   = (cnt == 16'd0);
  assign data_mask = 8'hFF >> (2'd3 - cfg_bits);

  always_comb begin
    state_next   = state;
    txd_next     = txd;
    pop          = 1'b0;
    shift        = 1'b0;
    stop_advance = 1'b0;
    case (state)
      IDLE: begin
        txd_next = 1'b1;
        if (!empty) begin
          pop        = 1'b1;
          txd_next   = 1'b0;
          state_next = START;
        end
      end
      START: begin
        if (bit_end) begin
          txd_next   = shreg[0];
          state_next = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx == last_idx) begin
            txd_next   = par_en ? par_bit : 1'b1;
            state_next = par_en ? PARITY : STOP;
          end else begin
            shift    = 1'b1;
            txd_next = shreg[1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          txd_next   = 1'b1;
          state_next = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (snap_stop2 && !stop_second) begin
            stop_advance = 1'b1;
          end else if (!empty) begin
            pop        = 1'b1;
            txd_next   = 1'b0;
            state_next = START;
          end else begin
            txd_next   = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: begin
        txd_next   = 1'b1;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      txd   <= 1'b1;
    end else begin
      state <= state_next;
      txd   <= txd_next;
    end
  end

  // a pop both starts the frame and captures the format used for its whole duration
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt         <= '0;
      snap_period <= '0;
      shreg       <= '0;
      bit_idx     <= '0;
      last_idx    <= '0;
      par_en      <= 1'b0;
      par_bit     <= 1'b0;
      snap_stop2  <= 1'b0;
      stop_second <= 1'b0;
    end else if (pop) begin
      cnt         <= cfg_period;
      snap_period <= cfg_period;
      shreg       <= head;
      bit_idx     <= '0;
      last_idx    <= 3'd4 + {1'b0, cfg_bits};
      par_en      <= (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
      par_bit     <= (^(head & data_mask)) ^ (cfg_parity == 2'b10);
      snap_stop2  <= cfg_stop2;
      stop_second <= 1'b0;
    end else if (state != IDLE) begin
      cnt <= bit_end ? snap_period : cnt - 16'd1;
      if (shift) begin
        shreg   <= {1'b0, shreg[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
      if (stop_advance) stop_second <= 1'b1;
    end
  end

  assign full_o     = full;
  assign empty_o    = empty;
  assign level_o    = count;
  assign overflow_o = overflow;
  assign txd_o      = txd;
  assign busy_o     = (state != IDLE);

endmodule
